// File: rtl/brresolve_pipeline.sv
// Branch/JAL/JALR resolution: decode, compare, target, mispredict check, redirect and saturating counters.
// Latency PIPE (1 or 2) cycles from an accepted valid_i to valid_o.
// Never stalls itself; stall_i freezes every stage, flush_i kills all in-flight slots and wins over stall_i.
module brresolve_pipeline #(
   parameter int XLEN  = 32,
   parameter int PIPE  = 1,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [31:0]      instr_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  operand_a_i,
   input  logic [XLEN-1:0]  operand_b_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic             pred_taken_i,
   input  logic [XLEN-1:0]  pred_target_i,
   output logic             valid_o,
   output logic             br_sel_o,
   output logic             is_cf_o,
   output logic             redirect_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic [CNT_W-1:0] br_count_o,
   output logic [CNT_W-1:0] mispred_count_o
);

   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;

   logic [4:0]      opc;
   logic            d_br, d_jalr, d_j, d_eq, d_lts, d_ltu;
   logic [2:0]      d_f3;
   logic [XLEN-1:0] jalr_sum, d_tgt, d_pc4;

   logic            s_vld, s_br, s_j, s_eq, s_lts, s_ltu, s_pt;
   logic [2:0]      s_f3;
   logic [XLEN-1:0] s_tgt, s_pc4, s_ptgt;

   logic            lt, cond, taken, is_cf, mispred;
   logic [XLEN-1:0] next_pc;

   logic            out_vld_q, out_taken_q, out_cf_q, out_mis_q;
   logic [XLEN-1:0] out_pc_q;
   logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;
   logic            retire;

   logic unused_instr;
   assign unused_instr = ^{instr_i[31:15], instr_i[11:7], instr_i[1:0]};

   always_comb begin
      opc      = instr_i[6:2];
      d_br     = (opc == OP_BRANCH);
      d_jalr   = (opc == OP_JALR);
      d_j      = (opc == OP_JAL) || d_jalr;
      d_f3     = instr_i[14:12];
      d_eq     = (operand_a_i == operand_b_i);
      d_lts    = ($signed(operand_a_i) < $signed(operand_b_i));
      d_ltu    = (operand_a_i < operand_b_i);
      jalr_sum = operand_a_i + imm_i;
      d_tgt    = d_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_i + imm_i);
      d_pc4    = pc_i + XLEN'(4);
   end

   generate
      if (PIPE == 2) begin : g_stage1
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               s_vld  <= 1'b0;
               s_br   <= 1'b0;
               s_j    <= 1'b0;
               s_f3   <= '0;
               s_eq   <= 1'b0;
               s_lts  <= 1'b0;
               s_ltu  <= 1'b0;
               s_tgt  <= '0;
               s_pc4  <= '0;
               s_pt   <= 1'b0;
               s_ptgt <= '0;
            end else begin
               if (flush_i)
                  s_vld <= 1'b0;
               else if (!stall_i)
                  s_vld <= valid_i;
               // data follows the stall only; a flushed slot may leave stale data behind
               if (!stall_i) begin
                  s_br   <= d_br;
                  s_j    <= d_j;
                  s_f3   <= d_f3;
                  s_eq   <= d_eq;
                  s_lts  <= d_lts;
                  s_ltu  <= d_ltu;
                  s_tgt  <= d_tgt;
                  s_pc4  <= d_pc4;
                  s_pt   <= pred_taken_i;
                  s_ptgt <= pred_target_i;
               end
            end
         end
      end else begin : g_pass
         always_comb begin
            s_vld  = valid_i;
            s_br   = d_br;
            s_j    = d_j;
            s_f3   = d_f3;
            s_eq   = d_eq;
            s_lts  = d_lts;
            s_ltu  = d_ltu;
            s_tgt  = d_tgt;
            s_pc4  = d_pc4;
            s_pt   = pred_taken_i;
            s_ptgt = pred_target_i;
         end
      end
   endgenerate

   // funct3[1] selects unsigned compare, funct3[0] inverts; 010/011 never take
   always_comb begin
      lt = s_f3[1] ? s_ltu : s_lts;
      if (s_f3[2])
         cond = lt ^ s_f3[0];
      else
         cond = s_f3[1] ? 1'b0 : (s_eq ^ s_f3[0]);
      taken   = s_j || (s_br && cond);
      is_cf   = s_j || s_br;
      mispred = (taken != s_pt) || (taken && (s_tgt != s_ptgt));
      next_pc = taken ? s_tgt : s_pc4;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_vld_q   <= 1'b0;
         out_taken_q <= 1'b0;
         out_cf_q    <= 1'b0;
         out_mis_q   <= 1'b0;
         out_pc_q    <= '0;
      end else begin
         if (flush_i)
            out_vld_q <= 1'b0;
         else if (!stall_i)
            out_vld_q <= s_vld;
         if (!stall_i) begin
            out_taken_q <= taken;
            out_cf_q    <= is_cf;
            out_mis_q   <= mispred;
            out_pc_q    <= next_pc;
         end
      end
   end

   assign retire = out_vld_q && !stall_i && !flush_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else if (retire) begin
         if (out_cf_q && !(&br_cnt_q))
            br_cnt_q <= br_cnt_q + 1'b1;
         if (out_mis_q && !(&mis_cnt_q))
            mis_cnt_q <= mis_cnt_q + 1'b1;
      end
   end

   assign valid_o         = out_vld_q;
   assign br_sel_o        = out_taken_q;
   assign is_cf_o         = out_cf_q;
   assign redirect_o      = out_vld_q && out_mis_q;
   assign redirect_pc_o   = out_pc_q;
   assign br_count_o      = br_cnt_q;
   assign mispred_count_o = mis_cnt_q;

endmodule

// File: tb/tb_brresolve_pipeline.sv
// Scoreboard bench: u1 is PIPE=1/CNT_W=4, u2 is PIPE=2/CNT_W=32, both fed the same stimulus.
// Expected responses are queued at issue and checked by a negedge monitor.
module tb_brresolve_pipeline;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, pred_taken_i = 1'b0;
   logic [31:0] instr_i = '0, pc_i = '0, opa = '0, opb = '0, imm_i = '0, pred_target_i = '0;

   logic        v1, br1, cf1, rd1, v2, br2, cf2, rd2;
   logic [31:0] npc1, npc2, bc2, mc2;
   logic [3:0]  bc1, mc1;

   always #5 clk = ~clk;

   brresolve_pipeline #(.XLEN(32), .PIPE(1), .CNT_W(4)) u1 (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
      .instr_i(instr_i), .pc_i(pc_i), .operand_a_i(opa), .operand_b_i(opb), .imm_i(imm_i),
      .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
      .valid_o(v1), .br_sel_o(br1), .is_cf_o(cf1), .redirect_o(rd1), .redirect_pc_o(npc1),
      .br_count_o(bc1), .mispred_count_o(mc1));

   brresolve_pipeline #(.XLEN(32), .PIPE(2), .CNT_W(32)) u2 (
      .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
      .instr_i(instr_i), .pc_i(pc_i), .operand_a_i(opa), .operand_b_i(opb), .imm_i(imm_i),
      .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
      .valid_o(v2), .br_sel_o(br2), .is_cf_o(cf2), .redirect_o(rd2), .redirect_pc_o(npc2),
      .br_count_o(bc2), .mispred_count_o(mc2));

   typedef struct packed {
      logic [31:0] ins, pc, a, b, imm;
      logic        pt;
      logic [31:0] pg;
      logic        t, c, r;
      logic [31:0] n;
   } vec_t;

   // instr, pc, a, b, imm, pred_taken, pred_target | taken, is_cf, redirect, next pc
   vec_t vt [0:12] = '{
      '{32'h4063, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h120},
      '{32'h6063, 32'h104, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h108},
      '{32'h0067, 32'h200, 32'h1003, 32'h0, 32'h4, 1'b1, 32'h1006, 1'b1, 1'b1, 1'b0, 32'h1006},
      '{32'h0067, 32'h204, 32'h1003, 32'h0, 32'h4, 1'b1, 32'h1007, 1'b1, 1'b1, 1'b1, 32'h1006},
      '{32'h0063, 32'h300, 32'h5, 32'h5, 32'h10, 1'b1, 32'h310, 1'b1, 1'b1, 1'b0, 32'h310},
      '{32'h1063, 32'h304, 32'h5, 32'h5, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h308},
      '{32'h0033, 32'h308, 32'h0, 32'h0, 32'h0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 32'h30C},
      '{32'h5063, 32'h400, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF0, 1'b1, 32'h3F0, 1'b0, 1'b1, 1'b1, 32'h404},
      '{32'h7063, 32'h400, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF0, 1'b1, 32'h3F0, 1'b1, 1'b1, 1'b0, 32'h3F0},
      '{32'h2063, 32'h500, 32'h7, 32'h7, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h504},
      '{32'h006F, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h8, 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 32'h4},
      '{32'h0033, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0},
      '{32'h006F, 32'h600, 32'h0, 32'h0, 32'h100, 1'b1, 32'h704, 1'b1, 1'b1, 1'b1, 32'h700}
   };

   vec_t   q [2][$];
   longint mb [2] = '{64'd0, 64'd0};
   longint mm [2] = '{64'd0, 64'd0};
   longint lim [2] = '{64'd15, 64'hFFFFFFFF};
   int     total = 0;
   int     bad = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic mon(input int k, input logic v, input logic br, input logic cf, input logic rd,
                      input logic [31:0] npc, input logic [31:0] bc, input logic [31:0] mc);
      vec_t e;
      chk($sformatf("u%0d.br_count", k + 1), 64'(bc), mb[k]);
      chk($sformatf("u%0d.mispred_count", k + 1), 64'(mc), mm[k]);
      if (!v) begin
         chk($sformatf("u%0d.redirect_idle", k + 1), 64'(rd), 64'd0);
      end else if (q[k].size() == 0) begin
         total++;
         bad++;
         $display("FAIL u%0d.spurious_valid got=1 exp=0 t=%0t", k + 1, $time);
      end else begin
         e = q[k][0];
         chk($sformatf("u%0d.br_sel pc=%0h", k + 1, e.pc), 64'(br), 64'(e.t));
         chk($sformatf("u%0d.is_cf pc=%0h", k + 1, e.pc), 64'(cf), 64'(e.c));
         chk($sformatf("u%0d.redirect pc=%0h", k + 1, e.pc), 64'(rd), 64'(e.r));
         chk($sformatf("u%0d.redirect_pc pc=%0h", k + 1, e.pc), 64'(npc), 64'(e.n));
         if (!stall_i && !flush_i) begin
            void'(q[k].pop_front());
            if (e.c && mb[k] < lim[k]) mb[k]++;
            if (e.r && mm[k] < lim[k]) mm[k]++;
         end
      end
      if (flush_i) q[k].delete();
   endtask

   always @(negedge clk) begin
      if (!rst_ni) begin
         for (int k = 0; k < 2; k++) begin
            q[k].delete();
            mb[k] = 0;
            mm[k] = 0;
         end
      end else begin
         mon(0, v1, br1, cf1, rd1, npc1, 32'(bc1), 32'(mc1));
         mon(1, v2, br2, cf2, rd2, npc2, bc2, mc2);
      end
   end

   task automatic issue(input vec_t s, input logic st, input logic fl);
      @(posedge clk);
      #1;
      valid_i       = 1'b1;
      instr_i       = s.ins;
      pc_i          = s.pc;
      opa           = s.a;
      opb           = s.b;
      imm_i         = s.imm;
      pred_taken_i  = s.pt;
      pred_target_i = s.pg;
      stall_i       = st;
      flush_i       = fl;
      if (!st && !fl) begin
         q[0].push_back(s);
         q[1].push_back(s);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         valid_i = 1'b0;
         stall_i = 1'b0;
         flush_i = 1'b0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".u1.outs"}, 64'({v1, br1, cf1, rd1, npc1, bc1, mc1}), 64'd0);
      chk({tag, ".u2.valid"}, 64'({v2, br2, cf2, rd2}), 64'd0);
      chk({tag, ".u2.redirect_pc"}, 64'(npc2), 64'd0);
      chk({tag, ".u2.counts"}, {bc2, mc2}, 64'd0);
   endtask

   initial begin
      #2 rst_ni = 1'b0;
      #20;
      chk_zero("reset");
      @(negedge clk);
      #1 rst_ni = 1'b1;

      // first-result latency: PIPE cycles after acceptance
      issue(vt[0], 1'b0, 1'b0);
      @(negedge clk);
      chk("lat.u1.c0", 64'(v1), 64'd0);
      chk("lat.u2.c0", 64'(v2), 64'd0);
      idle(1);
      @(negedge clk);
      chk("lat.u1.c1", 64'(v1), 64'd1);
      chk("lat.u2.c1", 64'(v2), 64'd0);
      idle(1);
      @(negedge clk);
      chk("lat.u1.c2", 64'(v1), 64'd0);
      chk("lat.u2.c2", 64'(v2), 64'd1);
      idle(2);

      for (int i = 0; i < 13; i++) issue(vt[i], 1'b0, 1'b0);
      idle(4);

      // stall three cycles mid-stream, then flush while still stalled
      issue(vt[4], 1'b0, 1'b0);
      issue(vt[5], 1'b0, 1'b0);
      issue(vt[6], 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) issue(vt[0], 1'b1, 1'b0);
      issue(vt[1], 1'b1, 1'b1);
      idle(1);
      @(negedge clk);
      chk("flush.u1.valid", 64'(v1), 64'd0);
      chk("flush.u2.valid", 64'(v2), 64'd0);
      idle(3);

      // saturation of the 4-bit counters
      for (int i = 0; i < 17; i++) issue(vt[0], 1'b0, 1'b0);
      idle(4);
      chk("sat.u1.br_count", 64'(bc1), 64'hF);
      chk("sat.u1.mispred_count", 64'(mc1), 64'hF);

      // asynchronous reset between edges, mid-stream
      issue(vt[0], 1'b0, 1'b0);
      issue(vt[4], 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      #1 rst_ni = 1'b1;

      issue(vt[7], 1'b0, 1'b0);
      issue(vt[8], 1'b0, 1'b0);
      issue(vt[3], 1'b0, 1'b0);
      idle(4);
      chk("drain.u1", 64'(q[0].size()), 64'd0);
      chk("drain.u2", 64'(q[1].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
